// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder and the load/store alignment logic.
package mem_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmr_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads (little-endian).
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]           size,
    input  logic [1:0]           lane,
    input  logic                 is_unsigned,
    input  logic [31:0]          raw_word,
    input  logic [31:0]          store_data,
    output logic [NUM_LANES-1:0] byte_en,
    output logic [31:0]          store_word,
    output logic [31:0]          load_data,
    output logic                 misalign
);
    logic [NUM_LANES-1:0][7:0] raw_lanes;
    logic [7:0]                sel_byte;
    logic [15:0]               sel_half;
    mem_size_t                 sz;

    assign raw_lanes = raw_word;
    assign sel_byte  = raw_lanes[lane];
    assign sel_half  = lane[1] ? raw_word[31:16] : raw_word[15:0];
    assign sz        = mem_size_t'(size);

    // Store data is replicated across lanes; byte_en picks which lanes land.
    // The illegal size encoding is reported through misalign as well.
    always_comb begin
        byte_en    = '0;
        store_word = store_data;
        load_data  = '0;
        misalign   = 1'b0;
        case (sz)
            MEM_BYTE: begin
                byte_en[lane] = 1'b1;
                store_word    = {4{store_data[7:0]}};
                load_data     = {{24{~is_unsigned & sel_byte[7]}}, sel_byte};
            end
            MEM_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{~is_unsigned & sel_half[15]}}, sel_half};
                misalign   = lane[0];
            end
            MEM_WORD: begin
                byte_en   = 4'b1111;
                load_data = raw_word;
                misalign  = |lane;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM endpoint for the core's load/store port: one request at a time,
// fixed wait states, registered response held until the requester takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    dmr_state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    mem_req_t   req_q, cur;
    logic       accept, commit, out_of_range, misalign, err;
    logic [AW-1:0]             idx;
    logic [NUM_LANES-1:0]      be;
    logic [31:0]               st_word, ld_data;
    logic [NUM_LANES-1:0][7:0] ram [DEPTH_WORDS];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid & req_ready;

    // With zero wait states the commit edge is the accept edge, so the live
    // request is used while idle and the latched copy otherwise.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur.we          = req_we;
            cur.addr        = req_addr;
            cur.size        = req_size;
            cur.is_unsigned = req_unsigned;
            cur.wdata       = req_wdata;
        end
    end

    assign idx          = cur.addr[2 +: AW];
    assign out_of_range = |cur.addr[31:AW+2];
    assign err          = out_of_range | misalign;

    lsu_align u_align (
        .size        (cur.size),
        .lane        (cur.addr[1:0]),
        .is_unsigned (cur.is_unsigned),
        .raw_word    (ram[idx]),
        .store_data  (cur.wdata),
        .byte_en     (be),
        .store_word  (st_word),
        .load_data   (ld_data),
        .misalign    (misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_n   = 4'(WAIT_CYCLES);
                state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = RESP;
            end
            RESP: if (resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign commit = ~rst & (state != RESP) & (state_n == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) req_q <= cur;
            if (commit) begin
                resp_err   <= err;
                resp_rdata <= (err | cur.we) ? 32'd0 : ld_data;
            end
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && cur.we && !err) begin
            for (int i = 0; i < NUM_LANES; i++)
                if (be[i]) ram[idx][i] <= st_word[8*i +: 8];
        end
    end

endmodule
